// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage with EX/MEM register and iterative multiplier
//
// Purpose: computes the ALU result for the decoded op, drives the combinational
// forwarding bus back to decode, and holds the EX/MEM pipeline register. MUL runs
// on a shift-add multiplier and stalls the front end while it iterates.
//
// Optional feature: define EX_MUL_EARLY_TERM_EN to end the multiply as soon as
// the remaining multiplier bits are all zero (results are identical either way).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush_i           kill the current EX instruction, bubble into MEM
//   aluop_i           operation code from decode
//   rs_data_i         operand 1
//   rt_data_i         operand 2
//   w_reg_addr_i      destination register
//   wd_i              write-enable request
//   ex_data_o         forwarding data (combinational)
//   ex_wd_o           forwarding write-valid (combinational)
//   ex_addr_o         forwarding destination (combinational)
//   stall_req_o       hold PC, IF/ID and ID/EX (combinational)
//   mem_data_o        registered result to MEM
//   mem_wd_o          registered write-enable to MEM
//   mem_addr_o        registered destination to MEM
module ex_stage #(
  parameter int DATA_W    = 32,
  parameter int MUL_CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [4:0]        w_reg_addr_i,
  input  logic              wd_i,
  output logic [DATA_W-1:0] ex_data_o,
  output logic              ex_wd_o,
  output logic [4:0]        ex_addr_o,
  output logic              stall_req_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wd_o,
  output logic [4:0]        mem_addr_o
);

  localparam logic [7:0] OP_SLL  = 8'h00;
  localparam logic [7:0] OP_BEQ  = 8'h04;
  localparam logic [7:0] OP_ORI  = 8'h0d;
  localparam logic [7:0] OP_LUI  = 8'h0f;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_MUL  = 8'h82;

  localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                state;
  logic [DATA_W-1:0]     acc;
  logic [DATA_W-1:0]     mcand;
  logic [DATA_W-1:0]     mplier;
  logic [MUL_CNT_W-1:0]  cnt;

  logic [DATA_W-1:0]     alu_res;
  logic                  legal;
  logic                  mul_start;
  logic                  busy;
  logic [DATA_W-1:0]     mplier_nx;

  // Single-cycle ALU; legal marks ops that may write a register (beq does not).
  always_comb begin
    alu_res = '0;
    legal   = 1'b0;
    case (aluop_i)
      OP_ADDU: begin alu_res = rs_data_i + rt_data_i;      legal = 1'b1; end
      OP_AND:  begin alu_res = rs_data_i & rt_data_i;      legal = 1'b1; end
      OP_OR:   begin alu_res = rs_data_i | rt_data_i;      legal = 1'b1; end
      OP_XOR:  begin alu_res = rs_data_i ^ rt_data_i;      legal = 1'b1; end
      OP_ORI:  begin alu_res = rs_data_i | rt_data_i;      legal = 1'b1; end
      OP_LUI:  begin alu_res = rt_data_i;                  legal = 1'b1; end
      OP_SLL:  begin alu_res = rt_data_i << rs_data_i[4:0]; legal = 1'b1; end
      OP_MUL:  legal = 1'b1;
      OP_BEQ:  legal = 1'b0;
      default: legal = 1'b0;
    endcase
  end

  assign mul_start = (state == S_IDLE) && (aluop_i == OP_MUL) && wd_i;
  // busy covers the launch cycle and every iteration; DONE is already free to forward.
  assign busy      = mul_start || (state == S_BUSY);
  assign mplier_nx = mplier >> 1;

  // Reset and flush both override a stall so the front end never freezes on a killed op.
  assign stall_req_o = busy && rst_n && !flush_i;
  assign ex_data_o   = (state == S_DONE) ? acc : alu_res;
  assign ex_wd_o     = wd_i && (legal || (state == S_DONE)) &&
                       (w_reg_addr_i != 5'd0) && !busy;
  assign ex_addr_o   = w_reg_addr_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      mem_data_o <= '0;
      mem_wd_o   <= 1'b0;
      mem_addr_o <= '0;
    end else if (flush_i) begin
      state      <= S_IDLE;
      mem_data_o <= '0;
      mem_wd_o   <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mul_start) begin
            mcand  <= rs_data_i;
            mplier <= rt_data_i;
            acc    <= '0;
            cnt    <= '0;
`ifdef EX_MUL_EARLY_TERM_EN
            state  <= (rt_data_i == '0) ? S_DONE : S_BUSY;
`else
            state  <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier_nx;
          cnt    <= cnt + 1'b1;
`ifdef EX_MUL_EARLY_TERM_EN
          if ((mplier_nx == '0) || (cnt == CNT_LAST)) begin
            state <= S_DONE;
          end
`else
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // While the multiplier holds the stage, MEM receives bubbles.
      if (busy) begin
        mem_data_o <= '0;
        mem_wd_o   <= 1'b0;
        mem_addr_o <= '0;
      end else begin
        mem_data_o <= ex_data_o;
        mem_wd_o   <= ex_wd_o;
        mem_addr_o <= ex_addr_o;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard testbench for ex_stage
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic [4:0]  w_reg_addr_i;
  logic        wd_i;
  logic [31:0] ex_data_o;
  logic        ex_wd_o;
  logic [4:0]  ex_addr_o;
  logic        stall_req_o;
  logic [31:0] mem_data_o;
  logic        mem_wd_o;
  logic [4:0]  mem_addr_o;

  int checks   = 0;
  int failures = 0;
  logic active = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic        wd;
    logic [4:0]  a;
  } exp_t;

  exp_t sb[$];

  ex_stage #(.DATA_W(32), .MUL_CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .aluop_i      (aluop_i),
    .rs_data_i    (rs_data_i),
    .rt_data_i    (rt_data_i),
    .w_reg_addr_i (w_reg_addr_i),
    .wd_i         (wd_i),
    .ex_data_o    (ex_data_o),
    .ex_wd_o      (ex_wd_o),
    .ex_addr_o    (ex_addr_o),
    .stall_req_o  (stall_req_o),
    .mem_data_o   (mem_data_o),
    .mem_wd_o     (mem_wd_o),
    .mem_addr_o   (mem_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what the instruction means, not how the stage computes it.
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [4:0] dest,
                                 input logic wd);
    exp_t e;
    logic [63:0] p;
    logic ok;
    ok  = 1'b1;
    e.d = 32'd0;
    case (op)
      8'h21: e.d = rs + rt;
      8'h24: e.d = rs & rt;
      8'h25: e.d = rs | rt;
      8'h26: e.d = rs ^ rt;
      8'h0d: e.d = rs | rt;
      8'h0f: e.d = rt;
      8'h00: e.d = rt << (rs % 32);
      8'h82: begin p = {32'd0, rs} * {32'd0, rt}; e.d = p[31:0]; end
      default: ok = 1'b0;
    endcase
    e.wd = wd && ok && (dest != 5'd0);
    e.a  = dest;
    return e;
  endfunction

  function automatic int mul_stall(input logic [31:0] rt);
    int hi;
`ifdef EX_MUL_EARLY_TERM_EN
    hi = -1;
    for (int i = 0; i < 32; i++) if (rt[i]) hi = i;
    return (hi < 0) ? 1 : 1 + hi + 1;
`else
    hi = 0;
    return 33 + hi;
`endif
  endfunction

  // Monitor: whenever the stage presents a finished instruction, compare the
  // forwarding bus now and the EX/MEM register after the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !flush_i && !stall_req_o && active) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ex_data", ex_data_o, e.d);
          chk("ex_wd", {31'd0, ex_wd_o}, {31'd0, e.wd});
          chk("ex_addr", {27'd0, ex_addr_o}, {27'd0, e.a});
          @(posedge clk);
          #1;
          chk("mem_data", mem_data_o, e.d);
          chk("mem_wd", {31'd0, mem_wd_o}, {31'd0, e.wd});
          chk("mem_addr", {27'd0, mem_addr_o}, {27'd0, e.a});
        end
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] dest, input logic wd);
    int n;
    @(posedge clk);
    #1;
    aluop_i      = op;
    rs_data_i    = rs;
    rt_data_i    = rt;
    w_reg_addr_i = dest;
    wd_i         = wd;
    active       = 1'b1;
    sb.push_back(model(op, rs, rt, dest, wd));
    n = 0;
    @(negedge clk);
    while (stall_req_o === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("stall_timeout", 32'(n), 32'd0);
    else if (op == 8'h82 && wd) chk("mul_stall_cycles", 32'(n), 32'(mul_stall(rt)));
    else chk("no_stall", 32'(n), 32'd0);
  endtask

  initial begin
    logic [7:0] ops [9];
    logic [7:0] op;
    logic [31:0] rt;
    ops = '{8'h21, 8'h24, 8'h25, 8'h26, 8'h0d, 8'h0f, 8'h00, 8'h04, 8'h82};

    // Reset with random inputs.
    rst_n        = 1'b0;
    flush_i      = 1'b0;
    aluop_i      = 8'h82;
    rs_data_i    = $urandom;
    rt_data_i    = $urandom;
    w_reg_addr_i = 5'($urandom);
    wd_i         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_mem_wd", {31'd0, mem_wd_o}, 32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    aluop_i = 8'h04;
    wd_i    = 1'b0;

    // Directed cases.
    issue(8'h21, 32'hFFFF_FFFF, 32'h2, 5'd5, 1'b1);
    issue(8'h00, 32'h4, 32'h1, 5'd7, 1'b1);
    issue(8'h0d, 32'h0, 32'h1234, 5'd0, 1'b1);
    issue(8'h82, 32'h0001_0003, 32'h0000_0005, 5'd9, 1'b1);
    issue(8'h82, 32'h8000_0001, 32'h8000_0001, 5'd3, 1'b1);
    issue(8'h82, 32'h1234_5678, 32'h0, 5'd4, 1'b1);
    issue(8'h82, 32'h7, 32'h6, 5'd0, 1'b1);
    issue(8'h04, 32'h5, 32'h5, 5'd2, 1'b1);

    // Flush at BUSY cycle 10 aborts the multiply.
    @(posedge clk);
    #1;
    active       = 1'b0;
    aluop_i      = 8'h82;
    rs_data_i    = 32'h3;
    rt_data_i    = 32'hFFFF_FFFF;
    w_reg_addr_i = 5'd6;
    wd_i         = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    aluop_i = 8'h04;
    wd_i    = 1'b0;
    chk("flush_mem_wd", {31'd0, mem_wd_o}, 32'd0);
    chk("flush_mem_data", mem_data_o, 32'd0);
    @(negedge clk);
    chk("post_flush_stall", {31'd0, stall_req_o}, 32'd0);
    issue(8'h21, 32'd100, 32'd23, 5'd8, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 9) ? 8'($urandom) : ops[$urandom_range(0, 8)];
      rt = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom;
      issue(op, $urandom, rt, 5'($urandom), (op == 8'h82) ? 1'b1 : 1'($urandom));
    end

    @(posedge clk);
    #1;
    active = 1'b0;
    aluop_i = 8'h04;
    wd_i    = 1'b0;
    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
